// File: rtl/memory_access_hs.sv
// Memory-access pipeline stage between execute and write-back: drives a req/gnt/rvalid
// data-memory handshake, builds store lanes and byte enables, and extends load data.
`timescale 1ns/1ps
module memory_access_hs #(
    parameter int XLEN       = 32,
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  i_ex_valid,
    input  logic                  i_ex_mem_rd,
    input  logic                  i_ex_mem_wr,
    input  logic                  i_ex_mem_to_reg,
    input  logic                  i_ex_reg_wr,
    input  logic [1:0]            i_ex_rw_sel,
    input  logic [XLEN-1:0]       i_ex_pc_plus_4,
    input  logic [XLEN-1:0]       i_ex_alu_result,
    input  logic [XLEN-1:0]       i_ex_reg_read_data2,
    input  logic [REG_ADDR_W-1:0] i_ex_reg_dest,
    input  logic [2:0]            i_ex_funct3,
    output logic                  o_dmem_req,
    output logic                  o_dmem_we,
    output logic [ADDR_W-1:0]     o_dmem_addr,
    output logic [XLEN-1:0]       o_dmem_wdata,
    output logic [XLEN/8-1:0]     o_dmem_be,
    input  logic                  i_dmem_gnt,
    input  logic                  i_dmem_rvalid,
    input  logic [XLEN-1:0]       i_dmem_rdata,
    output logic                  o_ma_stall,
    output logic                  o_ma_misaligned,
    output logic                  o_ma_valid,
    output logic                  o_ma_mem_to_reg,
    output logic                  o_ma_reg_wr,
    output logic [1:0]            o_ma_rw_sel,
    output logic [XLEN-1:0]       o_ma_pc_plus_4,
    output logic [XLEN-1:0]       o_ma_result,
    output logic [XLEN-1:0]       o_ma_read_data,
    output logic [REG_ADDR_W-1:0] o_ma_reg_dest
);
    localparam int BE_W  = XLEN / 8;
    localparam int OFF_W = (XLEN == 64) ? 3 : 2;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] a);
        logic m;
        case (sz)
            2'd0:    m = 1'b0;
            2'd1:    m = a[0];
            2'd2:    m = |a[1:0];
            default: m = (XLEN != 64) || (|a);
        endcase
        return m;
    endfunction

    function automatic logic [BE_W-1:0] make_be(input logic [1:0] sz, input logic [OFF_W-1:0] off);
        logic [7:0]      m8;
        logic [BE_W-1:0] m;
        case (sz)
            2'd0:    m8 = 8'h01;
            2'd1:    m8 = 8'h03;
            2'd2:    m8 = 8'h0F;
            default: m8 = 8'hFF;
        endcase
        m = m8[BE_W-1:0];
        return m << off;
    endfunction

    function automatic logic [XLEN-1:0] make_wdata(input logic [1:0] sz, input logic [XLEN-1:0] d);
        logic [XLEN-1:0] w;
        case (sz)
            2'd0:    w = {(XLEN/8){d[7:0]}};
            2'd1:    w = {(XLEN/16){d[15:0]}};
            2'd2:    w = {(XLEN/32){d[31:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // Size casts of signed slices sign-extend; unsigned slices zero-extend.
    function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] rd,
                                                    input logic [OFF_W-1:0] off,
                                                    input logic [2:0] f3);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] r;
        sh = rd >> {off, 3'b000};
        case (f3)
            3'b000:  r = XLEN'($signed(sh[7:0]));
            3'b001:  r = XLEN'($signed(sh[15:0]));
            3'b010:  r = XLEN'($signed(sh[31:0]));
            3'b100:  r = XLEN'(sh[7:0]);
            3'b101:  r = XLEN'(sh[15:0]);
            3'b110:  r = XLEN'(sh[31:0]);
            default: r = sh;
        endcase
        return r;
    endfunction

    state_t state_q, state_d;
    logic                  accept_pass, accept_mem, complete, stall, req;
    logic                  mem_op, misal;
    logic [ADDR_W-1:0]     addr_q;
    logic                  we_q;
    logic [XLEN-1:0]       wdata_q;
    logic [BE_W-1:0]       be_q;
    logic [2:0]            f3_q;
    logic                  wb_m2r_q, wb_regwr_q;
    logic [1:0]            wb_rwsel_q;
    logic [XLEN-1:0]       wb_pc4_q, wb_res_q;
    logic [REG_ADDR_W-1:0] wb_rd_q;
    logic                  ma_valid_q, ma_misal_q, ma_m2r_q, ma_regwr_q;
    logic [1:0]            ma_rwsel_q;
    logic [XLEN-1:0]       ma_pc4_q, ma_res_q, ma_rdata_q;
    logic [REG_ADDR_W-1:0] ma_rd_q;

    assign mem_op = i_ex_mem_rd | i_ex_mem_wr;
    assign misal  = is_misaligned(i_ex_funct3[1:0], i_ex_alu_result[2:0]);

    always_comb begin
        state_d     = state_q;
        accept_pass = 1'b0;
        accept_mem  = 1'b0;
        complete    = 1'b0;
        stall       = 1'b0;
        req         = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_ex_valid) begin
                    if (mem_op && !misal) begin
                        accept_mem = 1'b1;
                        stall      = 1'b1;
                        state_d    = REQ;
                    end else begin
                        accept_pass = 1'b1;
                    end
                end
            end
            REQ: begin
                req = 1'b1;
                if (i_dmem_gnt && we_q) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else if (i_dmem_gnt) begin
                    stall   = 1'b1;
                    state_d = WAIT;
                end else begin
                    stall = 1'b1;
                end
            end
            WAIT: begin
                if (i_dmem_rvalid) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else if (clk_en) begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            be_q       <= '0;
            f3_q       <= '0;
            wb_m2r_q   <= 1'b0;
            wb_regwr_q <= 1'b0;
            wb_rwsel_q <= '0;
            wb_pc4_q   <= '0;
            wb_res_q   <= '0;
            wb_rd_q    <= '0;
            ma_valid_q <= 1'b0;
            ma_misal_q <= 1'b0;
            ma_m2r_q   <= 1'b0;
            ma_regwr_q <= 1'b0;
            ma_rwsel_q <= '0;
            ma_pc4_q   <= '0;
            ma_res_q   <= '0;
            ma_rdata_q <= '0;
            ma_rd_q    <= '0;
        end else if (clk_en) begin
            ma_valid_q <= 1'b0;
            ma_misal_q <= 1'b0;
            // A memory op reaching accept_pass is a misaligned one: flag it, suppress write-back.
            if (accept_pass) begin
                ma_valid_q <= 1'b1;
                ma_misal_q <= mem_op;
                ma_regwr_q <= i_ex_reg_wr & ~mem_op;
                ma_m2r_q   <= i_ex_mem_to_reg;
                ma_rwsel_q <= i_ex_rw_sel;
                ma_pc4_q   <= i_ex_pc_plus_4;
                ma_res_q   <= i_ex_alu_result;
                ma_rd_q    <= i_ex_reg_dest;
            end
            if (accept_mem) begin
                addr_q     <= i_ex_alu_result[ADDR_W-1:0];
                we_q       <= i_ex_mem_wr;
                wdata_q    <= make_wdata(i_ex_funct3[1:0], i_ex_reg_read_data2);
                be_q       <= make_be(i_ex_funct3[1:0], i_ex_alu_result[OFF_W-1:0]);
                f3_q       <= i_ex_funct3;
                wb_m2r_q   <= i_ex_mem_to_reg;
                wb_regwr_q <= i_ex_reg_wr;
                wb_rwsel_q <= i_ex_rw_sel;
                wb_pc4_q   <= i_ex_pc_plus_4;
                wb_res_q   <= i_ex_alu_result;
                wb_rd_q    <= i_ex_reg_dest;
            end
            if (complete) begin
                ma_valid_q <= 1'b1;
                ma_regwr_q <= wb_regwr_q;
                ma_m2r_q   <= wb_m2r_q;
                ma_rwsel_q <= wb_rwsel_q;
                ma_pc4_q   <= wb_pc4_q;
                ma_res_q   <= wb_res_q;
                ma_rd_q    <= wb_rd_q;
                if (!we_q) begin
                    ma_rdata_q <= extend_load(i_dmem_rdata, addr_q[OFF_W-1:0], f3_q);
                end
            end
        end
    end

    assign o_dmem_req      = req;
    assign o_dmem_we       = we_q;
    assign o_dmem_addr     = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign o_dmem_wdata    = wdata_q;
    assign o_dmem_be       = be_q;
    assign o_ma_stall      = stall & ~rst;
    assign o_ma_misaligned = ma_misal_q;
    assign o_ma_valid      = ma_valid_q;
    assign o_ma_mem_to_reg = ma_m2r_q;
    assign o_ma_reg_wr     = ma_regwr_q;
    assign o_ma_rw_sel     = ma_rwsel_q;
    assign o_ma_pc_plus_4  = ma_pc4_q;
    assign o_ma_result     = ma_res_q;
    assign o_ma_read_data  = ma_rdata_q;
    assign o_ma_reg_dest   = ma_rd_q;
endmodule

// File: tb/tb_memory_access_hs.sv
// Directed bench for memory_access_hs: one XLEN=32 and one XLEN=64 instance sharing
// stimulus, a table of single transactions, and hand-written handshake sequences.
`timescale 1ns/1ps
module tb_memory_access_hs;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clk_en, ex_valid, use64;
    logic        mrd, mwr, m2r, regwr, gnt, rvalid;
    logic [1:0]  rwsel;
    logic [2:0]  f3;
    logic [4:0]  rdest;
    logic [63:0] pc4, alu, rs2, rdata;
    logic        ex_valid32, ex_valid64;

    logic        req32, we32, stall32, mis32, valid32, m2r32, regwr32;
    logic [31:0] addr32, wdata32, pc4o32, res32, rdo32;
    logic [3:0]  be32;
    logic [1:0]  rwsel32;
    logic [4:0]  rd32;
    logic        req64, we64, stall64, mis64, valid64, m2r64, regwr64;
    logic [63:0] addr64, wdata64, pc4o64, res64, rdo64;
    logic [7:0]  be64;
    logic [1:0]  rwsel64;
    logic [4:0]  rd64;

    assign ex_valid32 = ex_valid & ~use64;
    assign ex_valid64 = ex_valid & use64;

    memory_access_hs #(.XLEN(32), .ADDR_W(32), .REG_ADDR_W(5)) dut32 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .i_ex_valid(ex_valid32),
        .i_ex_mem_rd(mrd), .i_ex_mem_wr(mwr), .i_ex_mem_to_reg(m2r), .i_ex_reg_wr(regwr),
        .i_ex_rw_sel(rwsel), .i_ex_pc_plus_4(pc4[31:0]), .i_ex_alu_result(alu[31:0]),
        .i_ex_reg_read_data2(rs2[31:0]), .i_ex_reg_dest(rdest), .i_ex_funct3(f3),
        .o_dmem_req(req32), .o_dmem_we(we32), .o_dmem_addr(addr32), .o_dmem_wdata(wdata32),
        .o_dmem_be(be32), .i_dmem_gnt(gnt), .i_dmem_rvalid(rvalid), .i_dmem_rdata(rdata[31:0]),
        .o_ma_stall(stall32), .o_ma_misaligned(mis32), .o_ma_valid(valid32),
        .o_ma_mem_to_reg(m2r32), .o_ma_reg_wr(regwr32), .o_ma_rw_sel(rwsel32),
        .o_ma_pc_plus_4(pc4o32), .o_ma_result(res32), .o_ma_read_data(rdo32),
        .o_ma_reg_dest(rd32));

    memory_access_hs #(.XLEN(64), .ADDR_W(64), .REG_ADDR_W(5)) dut64 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .i_ex_valid(ex_valid64),
        .i_ex_mem_rd(mrd), .i_ex_mem_wr(mwr), .i_ex_mem_to_reg(m2r), .i_ex_reg_wr(regwr),
        .i_ex_rw_sel(rwsel), .i_ex_pc_plus_4(pc4), .i_ex_alu_result(alu),
        .i_ex_reg_read_data2(rs2), .i_ex_reg_dest(rdest), .i_ex_funct3(f3),
        .o_dmem_req(req64), .o_dmem_we(we64), .o_dmem_addr(addr64), .o_dmem_wdata(wdata64),
        .o_dmem_be(be64), .i_dmem_gnt(gnt), .i_dmem_rvalid(rvalid), .i_dmem_rdata(rdata),
        .o_ma_stall(stall64), .o_ma_misaligned(mis64), .o_ma_valid(valid64),
        .o_ma_mem_to_reg(m2r64), .o_ma_reg_wr(regwr64), .o_ma_rw_sel(rwsel64),
        .o_ma_pc_plus_4(pc4o64), .o_ma_result(res64), .o_ma_read_data(rdo64),
        .o_ma_reg_dest(rd64));

    logic        s_req, s_we, s_stall, s_mis, s_valid, s_regwr;
    logic [63:0] s_addr, s_wdata, s_res, s_rdat, s_pc4;
    logic [7:0]  s_be;
    logic [4:0]  s_rd;
    assign s_req   = use64 ? req64   : req32;
    assign s_we    = use64 ? we64    : we32;
    assign s_stall = use64 ? stall64 : stall32;
    assign s_mis   = use64 ? mis64   : mis32;
    assign s_valid = use64 ? valid64 : valid32;
    assign s_regwr = use64 ? regwr64 : regwr32;
    assign s_addr  = use64 ? addr64  : {32'h0, addr32};
    assign s_wdata = use64 ? wdata64 : {32'h0, wdata32};
    assign s_res   = use64 ? res64   : {32'h0, res32};
    assign s_rdat  = use64 ? rdo64   : {32'h0, rdo32};
    assign s_pc4   = use64 ? pc4o64  : {32'h0, pc4o32};
    assign s_be    = use64 ? be64    : {4'h0, be32};
    assign s_rd    = use64 ? rd64    : rd32;

    int total = 0;
    int bad   = 0;
    logic [63:0] last_rd [2];

    task automatic chk(input string vn, input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s: got %0h expected %0h", vn, nm, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        is64, mrd, mwr;
        logic [2:0]  f3;
        logic [63:0] addr, rs2, rdata;
        int          lat;
        logic        mis;
        logic [63:0] exp_rd, exp_addr, exp_wdata;
        logic [7:0]  exp_be;
    } vec_t;

    function automatic vec_t mk(string n, logic is64, logic r, logic w, logic [2:0] f,
                                logic [63:0] a, logic [63:0] d2, logic [63:0] rd, int lat,
                                logic mis, logic [63:0] erd, logic [63:0] ea, logic [7:0] ebe,
                                logic [63:0] ewd);
        vec_t v;
        v.name = n; v.is64 = is64; v.mrd = r; v.mwr = w; v.f3 = f; v.addr = a; v.rs2 = d2;
        v.rdata = rd; v.lat = lat; v.mis = mis; v.exp_rd = erd; v.exp_addr = ea;
        v.exp_be = ebe; v.exp_wdata = ewd;
        return v;
    endfunction

    // One transaction with gnt and rvalid tied high: ALU/misaligned 1 cycle, store 2, load 3.
    task automatic run_vec(input vec_t v, input int idx);
        int          cyc;
        logic        got_req, c_we, acc, ld;
        logic [63:0] c_addr, c_wdata, exp_res;
        logic [7:0]  c_be;
        logic [4:0]  exp_rdest;
        logic [63:0] exp_pc4;
        @(negedge clk);
        use64 = v.is64; mrd = v.mrd; mwr = v.mwr; f3 = v.f3; alu = v.addr; rs2 = v.rs2;
        rdata = v.rdata; gnt = 1'b1; rvalid = 1'b1; regwr = 1'b1;
        exp_pc4 = 64'(32'h1000 + 32'(idx * 4));
        pc4 = exp_pc4;
        exp_rdest = 5'(idx + 1);
        rdest = exp_rdest;
        ex_valid = 1'b1;
        cyc = 0; got_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0; c_be = '0;
        do begin
            @(posedge clk); #1;
            ex_valid = 1'b0;
            cyc++;
            if (s_req) begin
                got_req = 1'b1; c_we = s_we; c_addr = s_addr; c_wdata = s_wdata; c_be = s_be;
            end
        end while (!s_valid && cyc < 8);
        acc = (v.mrd | v.mwr) & ~v.mis;
        ld  = v.mrd & ~v.mwr;
        exp_res = v.is64 ? v.addr : {32'h0, v.addr[31:0]};
        if (ld && !v.mis) last_rd[v.is64] = v.exp_rd;
        chk(v.name, "latency", 64'(cyc), 64'(v.lat));
        chk(v.name, "valid", s_valid, 1);
        chk(v.name, "misaligned", s_mis, v.mis);
        chk(v.name, "reg_wr", s_regwr, !v.mis);
        chk(v.name, "result", s_res, exp_res);
        chk(v.name, "pc4", s_pc4, exp_pc4);
        chk(v.name, "reg_dest", 64'(s_rd), 64'(exp_rdest));
        chk(v.name, "read_data", s_rdat, last_rd[v.is64]);
        chk(v.name, "req_seen", got_req, acc);
        chk(v.name, "req_after", s_req, 0);
        if (acc) begin
            chk(v.name, "addr", c_addr, v.exp_addr);
            chk(v.name, "be", 64'(c_be), 64'(v.exp_be));
            chk(v.name, "we", c_we, v.mwr);
            if (v.mwr) chk(v.name, "wdata", c_wdata, v.exp_wdata);
        end
    endtask

    vec_t vecs [20];

    initial begin
        int n;
        vecs[0]  = mk("alu32", 0, 0, 0, 3'b000, 64'h12345678, 0, 0, 1, 0, 0, 0, 8'h0, 0);
        vecs[1]  = mk("lb",    0, 1, 0, 3'b000, 64'h13, 0, 64'h80AABBCC, 3, 0, 64'hFFFFFF80, 64'h10, 8'h8, 0);
        vecs[2]  = mk("lhu",   0, 1, 0, 3'b101, 64'h12, 0, 64'hABCD0000, 3, 0, 64'h0000ABCD, 64'h10, 8'hC, 0);
        vecs[3]  = mk("lh",    0, 1, 0, 3'b001, 64'h12, 0, 64'hABCD0000, 3, 0, 64'hFFFFABCD, 64'h10, 8'hC, 0);
        vecs[4]  = mk("lbu",   0, 1, 0, 3'b100, 64'h11, 0, 64'h11223344, 3, 0, 64'h33, 64'h10, 8'h2, 0);
        vecs[5]  = mk("lw",    0, 1, 0, 3'b010, 64'h20, 0, 64'h87654321, 3, 0, 64'h87654321, 64'h20, 8'hF, 0);
        vecs[6]  = mk("lw_mis", 0, 1, 0, 3'b010, 64'h22, 0, 0, 1, 1, 0, 0, 8'h0, 0);
        vecs[7]  = mk("lh_mis", 0, 1, 0, 3'b001, 64'h13, 0, 0, 1, 1, 0, 0, 8'h0, 0);
        vecs[8]  = mk("sb",    0, 0, 1, 3'b000, 64'h10000001, 64'hCAFEBABE, 0, 2, 0, 0, 64'h10000000, 8'h2, 64'hBEBEBEBE);
        vecs[9]  = mk("sh",    0, 0, 1, 3'b001, 64'h102, 64'h1234ABCD, 0, 2, 0, 0, 64'h100, 8'hC, 64'hABCDABCD);
        vecs[10] = mk("sw",    0, 0, 1, 3'b010, 64'h104, 64'hDEADBEEF, 0, 2, 0, 0, 64'h104, 8'hF, 64'hDEADBEEF);
        vecs[11] = mk("ld_on32", 0, 1, 0, 3'b011, 64'h8, 0, 0, 1, 1, 0, 0, 8'h0, 0);
        vecs[12] = mk("rdwr_sb", 0, 1, 1, 3'b000, 64'h3, 64'h55, 64'hFFFFFFFF, 2, 0, 0, 64'h0, 8'h8, 64'h55555555);
        vecs[13] = mk("sh_mis", 0, 0, 1, 3'b001, 64'h5, 64'h77, 0, 1, 1, 0, 0, 8'h0, 0);
        vecs[14] = mk("ld64",  1, 1, 0, 3'b011, 64'h8, 0, 64'h8000000000000001, 3, 0, 64'h8000000000000001, 64'h8, 8'hFF, 0);
        vecs[15] = mk("lwu64", 1, 1, 0, 3'b110, 64'h4, 0, 64'hFFFFFFFF00000000, 3, 0, 64'h00000000FFFFFFFF, 64'h0, 8'hF0, 0);
        vecs[16] = mk("lw64",  1, 1, 0, 3'b010, 64'hC, 0, 64'h8000000000000000, 3, 0, 64'hFFFFFFFF80000000, 64'h8, 8'hF0, 0);
        vecs[17] = mk("sd64",  1, 0, 1, 3'b011, 64'h10, 64'h0123456789ABCDEF, 0, 2, 0, 0, 64'h10, 8'hFF, 64'h0123456789ABCDEF);
        vecs[18] = mk("sb64",  1, 0, 1, 3'b000, 64'h25, 64'hAB, 0, 2, 0, 0, 64'h20, 8'h20, 64'hABABABABABABABAB);
        vecs[19] = mk("alu64", 1, 0, 0, 3'b000, 64'hFEDCBA9876543210, 0, 0, 1, 0, 0, 0, 8'h0, 0);

        last_rd[0] = '0; last_rd[1] = '0;
        rst = 1'b1; clk_en = 1'b1; ex_valid = 1'b0; use64 = 1'b0;
        mrd = 0; mwr = 0; m2r = 1; regwr = 1; gnt = 0; rvalid = 0;
        rwsel = 2'b01; f3 = 0; rdest = 0; pc4 = 0; alu = 0; rs2 = 0; rdata = 0;
        #1;
        chk("reset", "valid32", valid32, 0);
        chk("reset", "stall32", stall32, 0);
        chk("reset", "req32", req32, 0);
        chk("reset", "mis32", mis32, 0);
        chk("reset", "rdata32", rdo32, 0);
        chk("reset", "valid64", valid64, 0);
        chk("reset", "req64", req64, 0);
        chk("reset", "res64", res64, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 20; i++) run_vec(vecs[i], i);

        // Store held in REQ for three cycles without grant.
        @(negedge clk);
        use64 = 0; mrd = 0; mwr = 1; f3 = 3'b000; alu = 64'h10000001; rs2 = 64'hCAFEBABE;
        gnt = 0; rvalid = 0; ex_valid = 1;
        #1;
        chk("sb_wait", "stall_idle", s_stall, 1);
        chk("sb_wait", "req_idle", s_req, 0);
        @(posedge clk); #1 ex_valid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("sb_wait", "req", s_req, 1);
            chk("sb_wait", "be", 64'(s_be), 64'h2);
            chk("sb_wait", "wdata", s_wdata, 64'hBEBEBEBE);
            chk("sb_wait", "addr", s_addr, 64'h10000000);
            chk("sb_wait", "stall", s_stall, 1);
        end
        @(negedge clk) gnt = 1;
        #1;
        chk("sb_wait", "stall_gnt", s_stall, 0);
        chk("sb_wait", "req_gnt", s_req, 1);
        @(posedge clk); #1;
        chk("sb_wait", "valid", s_valid, 1);
        chk("sb_wait", "req_done", s_req, 0);
        gnt = 0;

        // Load stall length with grant in REQ and rvalid the next cycle.
        @(negedge clk);
        mrd = 1; mwr = 0; f3 = 3'b000; alu = 64'h13; rdata = 64'h80AABBCC;
        gnt = 1; rvalid = 1; ex_valid = 1;
        #1 n = int'(s_stall);
        @(posedge clk); #1 ex_valid = 0;
        @(negedge clk); #1 n += int'(s_stall);
        @(negedge clk); #1 n += int'(s_stall);
        chk("lb_stall", "stall_cycles", 64'(n), 2);
        @(posedge clk); #1;
        chk("lb_stall", "valid", s_valid, 1);
        chk("lb_stall", "read_data", s_rdat, 64'hFFFFFF80);

        // Misaligned exception is a single-cycle pulse.
        @(negedge clk);
        mrd = 1; mwr = 0; f3 = 3'b010; alu = 64'h22; ex_valid = 1;
        @(posedge clk); #1 ex_valid = 0;
        chk("mis_pulse", "mis", s_mis, 1);
        chk("mis_pulse", "reg_wr", s_regwr, 0);
        chk("mis_pulse", "req", s_req, 0);
        @(posedge clk); #1;
        chk("mis_pulse", "mis_clear", s_mis, 0);
        chk("mis_pulse", "valid_clear", s_valid, 0);

        // clk_en low freezes the FSM even with grant present.
        @(negedge clk);
        mrd = 0; mwr = 1; f3 = 3'b010; alu = 64'h200; rs2 = 64'h1; gnt = 0; ex_valid = 1;
        @(posedge clk); #1 ex_valid = 0;
        chk("clk_en", "req", s_req, 1);
        @(negedge clk); clk_en = 0; gnt = 1;
        @(posedge clk); #1;
        chk("clk_en", "req_held", s_req, 1);
        chk("clk_en", "valid_held", s_valid, 0);
        @(negedge clk) clk_en = 1;
        @(posedge clk); #1;
        chk("clk_en", "valid", s_valid, 1);
        chk("clk_en", "req_done", s_req, 0);
        gnt = 0;

        // Asynchronous reset while waiting for read data.
        @(negedge clk);
        mrd = 1; mwr = 0; f3 = 3'b010; alu = 64'h40; gnt = 1; rvalid = 0; ex_valid = 1;
        @(posedge clk); #1 ex_valid = 0;
        @(posedge clk); #1;
        chk("rst_wait", "stall_wait", s_stall, 1);
        chk("rst_wait", "req_wait", s_req, 0);
        #2 rst = 1;
        #1;
        chk("rst_wait", "stall", s_stall, 0);
        chk("rst_wait", "req", s_req, 0);
        chk("rst_wait", "valid", s_valid, 0);
        chk("rst_wait", "result", s_res, 0);
        chk("rst_wait", "read_data", s_rdat, 0);
        @(negedge clk);
        rst = 0; mrd = 0; mwr = 0; alu = 64'h10; rvalid = 1; ex_valid = 1;
        @(posedge clk); #1 ex_valid = 0;
        chk("rst_wait", "alu_valid", s_valid, 1);
        chk("rst_wait", "alu_result", s_res, 64'h10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
